schmidl_cox_frame_ctrl: RTL and testbench



---
 rtl/schmidl_cox_pkg.sv | 22 ++
 rtl/schmidl_cox_frame_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_schmidl_cox_frame_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/schmidl_cox_pkg.sv
// Shared types and helpers for the Schmidl-Cox detection/framing controller.
package schmidl_cox_pkg;

    localparam int unsigned DefLenW    = 16;
    localparam int unsigned DefMetricW = 32;
    localparam int unsigned MetricMaxW = 64;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StSearch  = 3'd1,
        StPlateau = 3'd2,
        StFrame   = 3'd3,
        StHoldoff = 3'd4
    } sc_state_e;

    // Strict unsigned comparison; callers zero-extend to MetricMaxW.
    function automatic logic metric_gt_thresh(input logic [MetricMaxW-1:0] metric,
                                              input logic [MetricMaxW-1:0] thresh);
        return metric > thresh;
    endfunction

endpackage

// File: rtl/schmidl_cox_frame_ctrl.sv
// Debounced plateau detector that frames packet_size samples after detection,
// then discards a hold-off window before re-arming.
module schmidl_cox_frame_ctrl
    import schmidl_cox_pkg::*;
#(
    parameter int unsigned ITEM_W      = 32,
    parameter int unsigned METRIC_W    = DefMetricW,
    parameter int unsigned LEN_W       = DefLenW,
    parameter int unsigned MIN_PLATEAU = 4
) (
    input  logic                ce_clk,
    input  logic                ce_rst_n,
    input  logic                enable,
    input  logic [LEN_W-1:0]    cfg_packet_size,
    input  logic [METRIC_W-1:0] cfg_threshold,
    input  logic [LEN_W-1:0]    cfg_holdoff_len,
    input  logic [ITEM_W-1:0]   s_tdata,
    input  logic [METRIC_W-1:0] s_metric,
    input  logic                s_tvalid,
    output logic                s_tready,
    output logic [ITEM_W-1:0]   m_tdata,
    output logic                m_tlast,
    output logic                m_tvalid,
    input  logic                m_tready,
    output logic                det_valid,
    output logic [31:0]         det_index,
    output logic [15:0]         frame_count,
    output logic [2:0]          state_o
);

    localparam int unsigned      PlatW   = $clog2(MIN_PLATEAU + 1);
    localparam logic [PlatW-1:0] PlatMax = PlatW'(MIN_PLATEAU);

    sc_state_e           state_q, state_d;
    logic [31:0]         sample_cnt_q;
    logic [PlatW-1:0]    plateau_q, plateau_d, plat_inc;
    logic [LEN_W-1:0]    pkt_size_q, holdoff_len_q, pkt_len_eff;
    logic [METRIC_W-1:0] thresh_q;
    logic [LEN_W-1:0]    remain_q, remain_d, hold_cnt_q, hold_cnt_d;
    logic [ITEM_W-1:0]   m_tdata_q;
    logic                m_tvalid_q, m_tlast_q;
    logic                det_valid_q;
    logic [31:0]         det_index_q;
    logic [15:0]         frame_count_q;

    logic beat, above, out_fire;
    logic latch_cfg, clr_cnt, det_fire, frame_done, load_out;

    assign s_tready    = (state_q == StFrame) ? (!m_tvalid_q || m_tready) : 1'b1;
    assign beat        = s_tvalid && s_tready;
    assign out_fire    = m_tvalid_q && m_tready;
    assign above       = metric_gt_thresh(MetricMaxW'(s_metric), MetricMaxW'(thresh_q));
    assign plat_inc    = plateau_q + PlatW'(1);
    assign pkt_len_eff = (pkt_size_q == '0) ? LEN_W'(1) : pkt_size_q;

    always_comb begin
        state_d    = state_q;
        plateau_d  = plateau_q;
        remain_d   = remain_q;
        hold_cnt_d = hold_cnt_q;
        latch_cfg  = 1'b0;
        clr_cnt    = 1'b0;
        det_fire   = 1'b0;
        frame_done = 1'b0;
        load_out   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (enable) begin
                    state_d   = StSearch;
                    latch_cfg = 1'b1;
                    clr_cnt   = 1'b1;
                    plateau_d = '0;
                end
            end
            StSearch: begin
                if (!enable) begin
                    state_d = StIdle;
                end else if (beat && above) begin
                    if (MIN_PLATEAU <= 1) begin
                        det_fire  = 1'b1;
                        state_d   = StFrame;
                        remain_d  = pkt_len_eff;
                        plateau_d = '0;
                    end else begin
                        plateau_d = PlatW'(1);
                        state_d   = StPlateau;
                    end
                end
            end
            StPlateau: begin
                if (!enable) begin
                    state_d   = StIdle;
                    plateau_d = '0;
                end else if (beat) begin
                    if (!above) begin
                        plateau_d = '0;
                        state_d   = StSearch;
                        latch_cfg = 1'b1;
                    end else if (plat_inc == PlatMax) begin
                        det_fire  = 1'b1;
                        state_d   = StFrame;
                        remain_d  = pkt_len_eff;
                        plateau_d = '0;
                    end else begin
                        plateau_d = plat_inc;
                    end
                end
            end
            StFrame: begin
                // Beats arriving after the last sample was captured are dropped.
                if (beat && remain_q != '0) begin
                    load_out = 1'b1;
                    remain_d = remain_q - LEN_W'(1);
                end
                if (out_fire && m_tlast_q) begin
                    frame_done = 1'b1;
                    if (!enable) begin
                        state_d = StIdle;
                    end else if (holdoff_len_q == '0) begin
                        state_d   = StSearch;
                        latch_cfg = 1'b1;
                    end else begin
                        state_d    = StHoldoff;
                        hold_cnt_d = holdoff_len_q;
                    end
                end
            end
            StHoldoff: begin
                if (!enable) begin
                    state_d = StIdle;
                end else if (beat) begin
                    hold_cnt_d = hold_cnt_q - LEN_W'(1);
                    if (hold_cnt_q == LEN_W'(1)) begin
                        state_d   = StSearch;
                        latch_cfg = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge ce_clk or negedge ce_rst_n) begin
        if (!ce_rst_n) begin
            state_q       <= StIdle;
            sample_cnt_q  <= '0;
            plateau_q     <= '0;
            pkt_size_q    <= '0;
            thresh_q      <= '0;
            holdoff_len_q <= '0;
            remain_q      <= '0;
            hold_cnt_q    <= '0;
            m_tdata_q     <= '0;
            m_tvalid_q    <= 1'b0;
            m_tlast_q     <= 1'b0;
            det_valid_q   <= 1'b0;
            det_index_q   <= '0;
            frame_count_q <= '0;
        end else begin
            state_q     <= state_d;
            plateau_q   <= plateau_d;
            remain_q    <= remain_d;
            hold_cnt_q  <= hold_cnt_d;
            det_valid_q <= det_fire;

            if (clr_cnt) begin
                sample_cnt_q <= '0;
            end else if (beat && enable) begin
                sample_cnt_q <= sample_cnt_q + 32'd1;
            end

            if (latch_cfg) begin
                pkt_size_q    <= cfg_packet_size;
                thresh_q      <= cfg_threshold;
                holdoff_len_q <= cfg_holdoff_len;
            end

            if (det_fire) begin
                det_index_q <= sample_cnt_q;
            end

            if (load_out) begin
                m_tdata_q  <= s_tdata;
                m_tvalid_q <= 1'b1;
                m_tlast_q  <= (remain_q == LEN_W'(1));
            end else if (out_fire) begin
                m_tvalid_q <= 1'b0;
                m_tlast_q  <= 1'b0;
            end

            if (frame_done) begin
                frame_count_q <= frame_count_q + 16'd1;
            end
        end
    end

    assign m_tdata     = m_tdata_q;
    assign m_tvalid    = m_tvalid_q;
    assign m_tlast     = m_tlast_q;
    assign det_valid   = det_valid_q;
    assign det_index   = det_index_q;
    assign frame_count = frame_count_q;
    assign state_o     = 3'(state_q);

endmodule

// File: tb/tb_schmidl_cox_frame_ctrl.sv
// Directed bench for schmidl_cox_frame_ctrl: debounce, framing, back-pressure,
// hold-off, enable drop and asynchronous reset.
module tb_schmidl_cox_frame_ctrl;

    localparam logic [31:0] THR       = 32'h0020_0000;
    localparam logic [31:0] HI        = 32'h0030_0000;
    localparam logic [31:0] LO        = 32'h0010_0000;
    localparam logic [31:0] DATA_BASE = 32'hA5C3_0000;
    localparam int          TAB_N     = 8192;

    logic        ce_clk = 1'b0;
    logic        ce_rst_n;
    logic        enable;
    logic [15:0] cfg_packet_size;
    logic [31:0] cfg_threshold;
    logic [15:0] cfg_holdoff_len;
    logic [31:0] s_tdata;
    logic [31:0] s_metric;
    logic        s_tvalid;
    logic        s_tready;
    logic [31:0] m_tdata;
    logic        m_tlast;
    logic        m_tvalid;
    logic        m_tready;
    logic        det_valid;
    logic [31:0] det_index;
    logic [15:0] frame_count;
    logic [2:0]  state_o;

    int checks = 0;
    int errors = 0;

    int          tx_idx;
    logic [31:0] metric_tab [TAB_N];
    logic [31:0] rx_data[$];
    logic        rx_last[$];
    int          det_count;
    logic [31:0] det_last;
    bit          stall_mode;
    bit          prev_stall;
    logic [31:0] held_data;
    logic        held_last;
    int          stall_viol;
    int          stall_seen;
    bit          seen_plateau;
    bit          seen_holdoff;

    schmidl_cox_frame_ctrl #(
        .ITEM_W     (32),
        .METRIC_W   (32),
        .LEN_W      (16),
        .MIN_PLATEAU(4)
    ) dut (
        .ce_clk         (ce_clk),
        .ce_rst_n       (ce_rst_n),
        .enable         (enable),
        .cfg_packet_size(cfg_packet_size),
        .cfg_threshold  (cfg_threshold),
        .cfg_holdoff_len(cfg_holdoff_len),
        .s_tdata        (s_tdata),
        .s_metric       (s_metric),
        .s_tvalid       (s_tvalid),
        .s_tready       (s_tready),
        .m_tdata        (m_tdata),
        .m_tlast        (m_tlast),
        .m_tvalid       (m_tvalid),
        .m_tready       (m_tready),
        .det_valid      (det_valid),
        .det_index      (det_index),
        .frame_count    (frame_count),
        .state_o        (state_o)
    );

    always #5 ce_clk = ~ce_clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, required finish earlier");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] exp_data(input int idx);
        return DATA_BASE ^ 32'(idx);
    endfunction

    task automatic drive_inputs();
        s_tdata  = exp_data(tx_idx);
        s_metric = (tx_idx >= 0 && tx_idx < TAB_N) ? metric_tab[tx_idx] : LO;
        m_tready = stall_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
    endtask

    // One clock: sample handshakes at negedge, advance the stream just after posedge.
    task automatic tick();
        logic beat;
        @(negedge ce_clk);
        beat = s_tvalid && s_tready;
        if (m_tvalid && m_tready) begin
            rx_data.push_back(m_tdata);
            rx_last.push_back(m_tlast);
        end
        if (prev_stall && (!m_tvalid || m_tdata !== held_data || m_tlast !== held_last))
            stall_viol++;
        prev_stall = m_tvalid && !m_tready;
        held_data  = m_tdata;
        held_last  = m_tlast;
        if (prev_stall) stall_seen++;
        if (state_o == 3'd2) seen_plateau = 1'b1;
        if (state_o == 3'd4) seen_holdoff = 1'b1;
        @(posedge ce_clk);
        #1;
        if (beat) tx_idx++;
        if (det_valid) begin
            det_count++;
            det_last = det_index;
        end
        drive_inputs();
    endtask

    task automatic clear_tab();
        for (int i = 0; i < TAB_N; i++) metric_tab[i] = LO;
    endtask

    task automatic set_hot(input int first, input int last);
        for (int i = first; i <= last; i++) metric_tab[i] = HI;
    endtask

    task automatic arm();
        s_tvalid = 1'b0;
        enable   = 1'b1;
        tick();
        tx_idx   = 0;
        s_tvalid = 1'b1;
        drive_inputs();
    endtask

    task automatic disarm();
        enable = 1'b0;
        tick();
        tick();
    endtask

    task automatic run_until_frames(input int target, input int budget, output bit timed_out);
        int n = 0;
        while (int'(frame_count) != target && n < budget) begin
            tick();
            n++;
        end
        timed_out = (int'(frame_count) != target);
    endtask

    task automatic test_reset();
        ce_rst_n = 1'b0;
        enable = 1'b0; s_tvalid = 1'b0; m_tready = 1'b1; stall_mode = 1'b0;
        cfg_packet_size = 16'd8; cfg_threshold = THR; cfg_holdoff_len = 16'd0;
        tx_idx = 0; det_count = 0; det_last = '0; prev_stall = 1'b0;
        clear_tab();
        drive_inputs();
        repeat (3) @(posedge ce_clk);
        #1;
        checks++; if (state_o !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state_o); end
        checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %b expected 0", m_tvalid); end
        checks++; if (m_tlast !== 1'b0 || det_valid !== 1'b0) begin errors++; $display("FAIL reset_flags: got tlast=%b det=%b expected 0 0", m_tlast, det_valid); end
        checks++; if (m_tdata !== 32'd0 || det_index !== 32'd0) begin errors++; $display("FAIL reset_data: got tdata=%h idx=%h expected 0 0", m_tdata, det_index); end
        checks++; if (frame_count !== 16'd0) begin errors++; $display("FAIL reset_frame_count: got %0d expected 0", frame_count); end
        @(negedge ce_clk);
        ce_rst_n = 1'b1;
        tick();
        checks++; if (state_o !== 3'd0 || s_tready !== 1'b1) begin errors++; $display("FAIL idle_after_reset: got state=%0d ready=%b expected 0 1", state_o, s_tready); end
    endtask

    task automatic test_debounce();
        int det0;
        clear_tab();
        for (int k = 0; k < 10; k++) begin
            set_hot(10 + 10 * k, 12 + 10 * k);
            metric_tab[13 + 10 * k] = THR;  // equal to threshold must not count
        end
        cfg_packet_size = 16'd8; cfg_holdoff_len = 16'd0; cfg_threshold = THR;
        rx_data.delete(); rx_last.delete();
        det0 = det_count; seen_plateau = 1'b0;
        arm();
        repeat (120) tick();
        checks++; if (det_count != det0) begin errors++; $display("FAIL debounce_no_det: got %0d detections expected 0", det_count - det0); end
        checks++; if (rx_data.size() != 0) begin errors++; $display("FAIL debounce_no_output: got %0d samples expected 0", rx_data.size()); end
        checks++; if (!seen_plateau) begin errors++; $display("FAIL debounce_plateau_seen: got 0 expected 1"); end
        checks++; if (state_o !== 3'd1) begin errors++; $display("FAIL debounce_state: got %0d expected 1", state_o); end
        disarm();
        checks++; if (state_o !== 3'd0) begin errors++; $display("FAIL debounce_disarm: got %0d expected 0", state_o); end
    endtask

    task automatic run_long_frame(input bit stall, input int exp_fc, input string tag);
        bit to;
        int det0, bad, nlast;
        clear_tab();
        set_hot(100, 103);
        cfg_packet_size = 16'd2304; cfg_holdoff_len = 16'd0; cfg_threshold = THR;
        rx_data.delete(); rx_last.delete();
        det0 = det_count; stall_mode = stall; stall_viol = 0; stall_seen = 0; prev_stall = 1'b0;
        arm();
        // Post-arm config changes must not affect this frame.
        cfg_threshold = 32'hFFFF_FFFF; cfg_packet_size = 16'd5;
        run_until_frames(exp_fc, 6000, to);
        stall_mode = 1'b0;
        checks++; if (to) begin errors++; $display("FAIL %s_timeout: got frame_count %0d expected %0d", tag, frame_count, exp_fc); end
        checks++; if (det_count - det0 != 1) begin errors++; $display("FAIL %s_det_count: got %0d expected 1", tag, det_count - det0); end
        checks++; if (det_last !== 32'd103) begin errors++; $display("FAIL %s_det_index: got %0d expected 103", tag, det_last); end
        checks++; if (rx_data.size() != 2304) begin errors++; $display("FAIL %s_len: got %0d expected 2304", tag, rx_data.size()); end
        bad = 0; nlast = 0;
        foreach (rx_data[k]) begin
            if (rx_data[k] !== exp_data(104 + k)) bad++;
            if (rx_last[k]) nlast++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL %s_data: got %0d wrong samples expected 0", tag, bad); end
        checks++; if (nlast != 1 || rx_last.size() == 0 || rx_last[rx_last.size() - 1] !== 1'b1) begin errors++; $display("FAIL %s_tlast: got %0d tlast beats expected 1 on final", tag, nlast); end
        checks++; if (frame_count !== 16'(exp_fc)) begin errors++; $display("FAIL %s_frame_count: got %0d expected %0d", tag, frame_count, exp_fc); end
        checks++; if (state_o !== 3'd1) begin errors++; $display("FAIL %s_state_after: got %0d expected 1", tag, state_o); end
        disarm();
        cfg_threshold = THR;
    endtask

    task automatic test_basic_frame();
        run_long_frame(1'b0, 1, "basic");
    endtask

    task automatic test_backpressure();
        run_long_frame(1'b1, 2, "bp");
        checks++; if (stall_viol != 0) begin errors++; $display("FAIL bp_stable: got %0d unstable stalls expected 0", stall_viol); end
        checks++; if (stall_seen == 0) begin errors++; $display("FAIL bp_stalls_seen: got 0 expected >0"); end
    endtask

    task automatic test_holdoff();
        bit to;
        int det0, bad;
        clear_tab();
        set_hot(100, 103);
        set_hot(367, 370);  // inside hold-off
        set_hot(767, 770);  // after hold-off
        cfg_packet_size = 16'd64; cfg_holdoff_len = 16'd500; cfg_threshold = THR;
        rx_data.delete(); rx_last.delete();
        det0 = det_count; seen_holdoff = 1'b0;
        arm();
        run_until_frames(4, 2000, to);
        checks++; if (to) begin errors++; $display("FAIL holdoff_timeout: got frame_count %0d expected 4", frame_count); end
        checks++; if (det_count - det0 != 2) begin errors++; $display("FAIL holdoff_det_count: got %0d expected 2", det_count - det0); end
        checks++; if (det_last !== 32'd770) begin errors++; $display("FAIL holdoff_det_index: got %0d expected 770", det_last); end
        checks++; if (rx_data.size() != 128) begin errors++; $display("FAIL holdoff_len: got %0d expected 128", rx_data.size()); end
        bad = 0;
        foreach (rx_data[k]) if (rx_data[k] !== exp_data(k < 64 ? 104 + k : 771 + k - 64)) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL holdoff_data: got %0d wrong samples expected 0", bad); end
        checks++; if (!seen_holdoff) begin errors++; $display("FAIL holdoff_state_seen: got 0 expected 1"); end
        disarm();
        checks++; if (state_o !== 3'd0) begin errors++; $display("FAIL holdoff_disarm: got %0d expected 0", state_o); end
    endtask

    task automatic test_enable_drop();
        bit to;
        int n, bad, nlast;
        clear_tab();
        set_hot(20, 23);
        cfg_packet_size = 16'd64; cfg_holdoff_len = 16'd0; cfg_threshold = THR;
        rx_data.delete(); rx_last.delete();
        arm();
        n = 0;
        while (frame_count != 16'd5 && n < 300) begin
            tick();
            if (rx_data.size() >= 10) enable = 1'b0;
            n++;
        end
        checks++; if (frame_count !== 16'd5) begin errors++; $display("FAIL endrop_frame_count: got %0d expected 5", frame_count); end
        checks++; if (state_o !== 3'd0) begin errors++; $display("FAIL endrop_state: got %0d expected 0", state_o); end
        checks++; if (rx_data.size() != 64) begin errors++; $display("FAIL endrop_len: got %0d expected 64", rx_data.size()); end
        bad = 0; nlast = 0;
        foreach (rx_data[k]) begin
            if (rx_data[k] !== exp_data(24 + k)) bad++;
            if (rx_last[k]) nlast++;
        end
        checks++; if (bad != 0 || nlast != 1 || rx_last.size() == 0 || rx_last[rx_last.size() - 1] !== 1'b1) begin errors++; $display("FAIL endrop_data: got %0d bad, %0d tlast expected 0, 1", bad, nlast); end
        clear_tab();
        set_hot(5, 8);
        cfg_packet_size = 16'd4;
        rx_data.delete(); rx_last.delete();
        arm();
        run_until_frames(6, 200, to);
        checks++; if (to || det_last !== 32'd8) begin errors++; $display("FAIL reenable_index: got %0d expected 8", det_last); end
        checks++; if (rx_data.size() != 4 || rx_data[0] !== exp_data(9)) begin errors++; $display("FAIL reenable_data: got len %0d expected 4 starting at index 9", rx_data.size()); end
        disarm();
    endtask

    task automatic test_reset_midframe();
        bit to;
        int n;
        clear_tab();
        set_hot(20, 23);
        cfg_packet_size = 16'd64; cfg_holdoff_len = 16'd0; cfg_threshold = THR;
        rx_data.delete(); rx_last.delete();
        arm();
        n = 0;
        while (rx_data.size() < 30 && n < 200) begin
            tick();
            n++;
        end
        checks++; if (m_tvalid !== 1'b1) begin errors++; $display("FAIL midframe_active: got tvalid=%b expected 1", m_tvalid); end
        #2;
        ce_rst_n = 1'b0;
        #1;
        checks++; if (m_tvalid !== 1'b0 || m_tlast !== 1'b0) begin errors++; $display("FAIL midframe_reset_out: got tvalid=%b tlast=%b expected 0 0", m_tvalid, m_tlast); end
        checks++; if (state_o !== 3'd0 || frame_count !== 16'd0) begin errors++; $display("FAIL midframe_reset_state: got state=%0d fc=%0d expected 0 0", state_o, frame_count); end
        enable = 1'b0; s_tvalid = 1'b0;
        @(negedge ce_clk);
        ce_rst_n = 1'b1;
        clear_tab();
        set_hot(10, 13);
        cfg_packet_size = 16'd0;
        rx_data.delete(); rx_last.delete();
        arm();
        run_until_frames(1, 100, to);
        checks++; if (to || det_last !== 32'd13) begin errors++; $display("FAIL zero_pkt_det: got %0d expected 13", det_last); end
        checks++; if (rx_data.size() != 1 || rx_data[0] !== exp_data(14) || rx_last[0] !== 1'b1) begin errors++; $display("FAIL zero_pkt_frame: got len %0d expected 1 sample index 14 with tlast", rx_data.size()); end
        disarm();
    endtask

    initial begin
        test_reset();
        test_debounce();
        test_basic_frame();
        test_backpressure();
        test_holdoff();
        test_enable_drop();
        test_reset_midframe();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
